// File: rtl/dp_ram_pkg.sv
// Shared types for the dual-port RAM with built-in march test.
// Holds the FSM state encoding and the per-element march description.
package dp_ram_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_DRAIN
    } mbist_state_e;

    typedef struct packed {
        logic descending;
        logic has_read;
        logic rd_one;
        logic has_write;
        logic wr_one;
    } march_elem_t;

    // March C- style sequence: w0 / r0w1 / r1w0 up, r0w1 / r1w0 / r0 down.
    function automatic march_elem_t march_elem(input mbist_state_e st);
        march_elem_t e;
        e = '0;
        case (st)
            ST_M0:   e = '{descending: 1'b0, has_read: 1'b0, rd_one: 1'b0, has_write: 1'b1, wr_one: 1'b0};
            ST_M1:   e = '{descending: 1'b0, has_read: 1'b1, rd_one: 1'b0, has_write: 1'b1, wr_one: 1'b1};
            ST_M2:   e = '{descending: 1'b0, has_read: 1'b1, rd_one: 1'b1, has_write: 1'b1, wr_one: 1'b0};
            ST_M3:   e = '{descending: 1'b1, has_read: 1'b1, rd_one: 1'b0, has_write: 1'b1, wr_one: 1'b1};
            ST_M4:   e = '{descending: 1'b1, has_read: 1'b1, rd_one: 1'b1, has_write: 1'b1, wr_one: 1'b0};
            ST_M5:   e = '{descending: 1'b1, has_read: 1'b1, rd_one: 1'b0, has_write: 1'b0, wr_one: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic mbist_state_e next_elem(input mbist_state_e st);
        mbist_state_e n;
        case (st)
            ST_M0:   n = ST_M1;
            ST_M1:   n = ST_M2;
            ST_M2:   n = ST_M3;
            ST_M3:   n = ST_M4;
            ST_M4:   n = ST_M5;
            ST_M5:   n = ST_DRAIN;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dp_ram_model.sv
// Simple dual-port storage array: one masked write port, one registered read port.
// Read returns the pre-write contents on a same-address access.
module dp_ram_model #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_addr][b] <= wr_data[b];
                end
            end
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/dp_ram_mbist.sv
// Dual-port RAM wrapper with zero-fill after reset, collision forwarding
// and a built-in march memory test sharing the array ports.
module dp_ram_mbist
    import dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH           = 4,
    parameter int DATA_WIDTH           = 32,
    parameter int INIT_MEMORY_ON_RESET = 1,
    parameter int BYPASS_ON_COLLISION  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_mask_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  ready,
    input  logic                  mbist_start,
    output logic                  mbist_busy,
    output logic                  mbist_done,
    output logic                  mbist_fail,
    output logic [ADDR_WIDTH-1:0] mbist_fail_addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    mbist_state_e          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  phase_reg, phase_next;
    march_elem_t           elem;
    mbist_state_e          nxt_state;
    logic                  elem_last, step, march_rd;

    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_wmask, ram_rd_data;

    logic                  rd_valid_reg, byp_hit_reg;
    logic [DATA_WIDTH-1:0] byp_data_reg, byp_mask_reg, data_hold_reg, fwd_data;
    logic                  cmp_valid_reg, cmp_exp_reg;
    logic [ADDR_WIDTH-1:0] cmp_addr_reg;
    logic                  done_reg, fail_reg;
    logic [ADDR_WIDTH-1:0] fail_addr_reg;
    logic                  start_accept;

    assign ready        = (state_reg == ST_IDLE);
    assign mbist_busy   = (state_reg != ST_INIT) && (state_reg != ST_IDLE);
    assign start_accept = ready && mbist_start;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        phase_next = phase_reg;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        ram_wdata  = data_in;
        ram_wmask  = data_mask_in;
        ram_re     = 1'b0;
        ram_raddr  = rd_addr;
        march_rd   = 1'b0;
        step       = 1'b0;
        elem       = march_elem(state_reg);
        nxt_state  = next_elem(state_reg);
        elem_last  = elem.descending ? (addr_reg == '0) : (addr_reg == ADDR_MAX);
        case (state_reg)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = addr_reg;
                ram_wdata = '0;
                ram_wmask = '1;
                if (addr_reg == ADDR_MAX) begin
                    state_next = ST_IDLE;
                    addr_next  = '0;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            ST_IDLE: begin
                ram_we = wr_en;
                ram_re = rd_en;
                if (mbist_start) begin
                    state_next = ST_M0;
                    addr_next  = '0;
                    phase_next = 1'b0;
                end
            end
            ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
                ram_waddr = addr_reg;
                ram_raddr = addr_reg;
                ram_wdata = {DATA_WIDTH{elem.wr_one}};
                ram_wmask = '1;
                // Read-then-write pairs use two cycles so the ports never collide.
                if (elem.has_read && !phase_reg) begin
                    ram_re   = 1'b1;
                    march_rd = 1'b1;
                    if (elem.has_write) begin
                        phase_next = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end else begin
                    ram_we = elem.has_write;
                    step   = 1'b1;
                end
                if (step) begin
                    phase_next = 1'b0;
                    if (elem_last) begin
                        state_next = nxt_state;
                        addr_next  = march_elem(nxt_state).descending ? ADDR_MAX : '0;
                    end else begin
                        addr_next = elem.descending ? addr_reg - 1'b1 : addr_reg + 1'b1;
                    end
                end
            end
            ST_DRAIN: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    dp_ram_model #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_we),
        .wr_addr(ram_waddr),
        .wr_data(ram_wdata),
        .wr_mask(ram_wmask),
        .rd_en  (ram_re),
        .rd_addr(ram_raddr),
        .rd_data(ram_rd_data)
    );

    // Per-bit merge of the colliding write onto the old word.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_fwd
            assign fwd_data[gi] = (byp_hit_reg && byp_mask_reg[gi]) ? byp_data_reg[gi] : ram_rd_data[gi];
        end
    endgenerate

    assign data_out        = rd_valid_reg ? fwd_data : data_hold_reg;
    assign rd_valid        = rd_valid_reg;
    assign mbist_done      = done_reg;
    assign mbist_fail      = fail_reg;
    assign mbist_fail_addr = fail_addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= (INIT_MEMORY_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            addr_reg      <= '0;
            phase_reg     <= 1'b0;
            rd_valid_reg  <= 1'b0;
            byp_hit_reg   <= 1'b0;
            data_hold_reg <= '0;
            cmp_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            phase_reg     <= phase_next;
            rd_valid_reg  <= ready && rd_en;
            byp_hit_reg   <= (BYPASS_ON_COLLISION != 0) && ready && rd_en && wr_en && (rd_addr == wr_addr);
            cmp_valid_reg <= march_rd;
            if (rd_valid_reg) begin
                data_hold_reg <= fwd_data;
            end
            if (start_accept) begin
                done_reg      <= 1'b0;
                fail_reg      <= 1'b0;
                fail_addr_reg <= '0;
            end else begin
                if (cmp_valid_reg && (ram_rd_data != {DATA_WIDTH{cmp_exp_reg}})) begin
                    fail_reg <= 1'b1;
                    if (!fail_reg) begin
                        fail_addr_reg <= cmp_addr_reg;
                    end
                end
                if (state_reg == ST_DRAIN) begin
                    done_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        cmp_addr_reg <= addr_reg;
        cmp_exp_reg  <= elem.rd_one;
        if (ready && rd_en && wr_en) begin
            byp_data_reg <= data_in;
            byp_mask_reg <= data_mask_in;
        end
    end

endmodule

// File: tb/tb_dp_ram_mbist.sv
// Directed bench for dp_ram_mbist: table-driven functional accesses on two
// instances (forwarding on/off) plus march, stuck-at and reset-abort sequences.
module tb_dp_ram_mbist;

    logic       clk;
    logic       rst;
    logic       rd_en, wr_en, mbist_start;
    logic [3:0] rd_addr, wr_addr;
    logic [7:0] data_in, data_mask_in;

    logic [7:0] data_out, data_out_nb;
    logic       rd_valid, rd_valid_nb, ready, ready_nb;
    logic       busy, busy_nb, done, done_nb, fail, fail_nb;
    logic [3:0] fail_addr, fail_addr_nb;

    int checks = 0;
    int passed = 0;
    logic inject = 1'b0;

    typedef struct {
        logic       rd_en;
        logic [3:0] rd_addr;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [7:0] data;
        logic [7:0] mask;
        logic       exp_valid;
        logic [7:0] exp_byp;
        logic [7:0] exp_nb;
    } vec_t;

    vec_t vecs [14];

    dp_ram_mbist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .INIT_MEMORY_ON_RESET(1), .BYPASS_ON_COLLISION(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .data_in(data_in), .data_mask_in(data_mask_in), .data_out(data_out), .rd_valid(rd_valid),
        .ready(ready), .mbist_start(mbist_start), .mbist_busy(busy), .mbist_done(done),
        .mbist_fail(fail), .mbist_fail_addr(fail_addr)
    );

    dp_ram_mbist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .INIT_MEMORY_ON_RESET(1), .BYPASS_ON_COLLISION(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .data_in(data_in), .data_mask_in(data_mask_in), .data_out(data_out_nb), .rd_valid(rd_valid_nb),
        .ready(ready_nb), .mbist_start(mbist_start), .mbist_busy(busy_nb), .mbist_done(done_nb),
        .mbist_fail(fail_nb), .mbist_fail_addr(fail_addr_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stuck-at-1 on bit 0 of word 5, re-imposed between active edges.
    always @(negedge clk) begin
        if (inject) dut.u_ram.mem[5][0] <= 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_ready(output int n, output int leaks);
        n = 0;
        leaks = 0;
        while (!ready && n < 40) begin
            tick;
            n++;
            if (rd_valid) leaks++;
        end
    endtask

    task automatic read_word(input logic [3:0] a, output logic [7:0] d, output logic v);
        rd_en = 1'b1;
        rd_addr = a;
        tick;
        rd_en = 1'b0;
        d = data_out;
        v = rd_valid;
    endtask

    // Runs a march from IDLE; stops early (asserting rst) when n reaches abort_at.
    task automatic run_march(input int abort_at, output int n, output int first_fail,
                             output logic [3:0] ff_addr, output int valid_leaks, output logic fail_before);
        mbist_start = 1'b1;
        tick;
        mbist_start = 1'b0;
        n = 0;
        first_fail = -1;
        ff_addr = 4'hx;
        valid_leaks = 0;
        fail_before = 1'b0;
        while (busy && n < 400 && n != abort_at) begin
            if (fail && first_fail < 0) begin
                first_fail = n;
                ff_addr = fail_addr;
            end
            if (rd_valid) valid_leaks++;
            mbist_start = (n == 50);
            tick;
            n++;
        end
        mbist_start = 1'b0;
        if (n == abort_at) begin
            fail_before = fail;
            rst = 1'b1;
            #1;
        end
        $display("march: busy_cycles=%0d first_fail_cycle=%0d fail_addr=%0d done=%0b fail=%0b",
                 n, first_fail, fail_addr, done, fail);
    endtask

    initial begin
        int n, leaks, ff, vl;
        logic [3:0] ffa;
        logic fb, v;
        logic [7:0] d;

        vecs[0]  = '{1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 4'd7, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 4'd0, 1'b1, 4'd3, 8'hA5, 8'hFF, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd3, 8'h0F, 8'h0F, 1'b0, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'hAF, 8'hAF};
        vecs[5]  = '{1'b1, 4'd3, 1'b1, 4'd3, 8'h50, 8'hF0, 1'b1, 8'h5F, 8'hAF};
        vecs[6]  = '{1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'h5F, 8'h5F};
        vecs[7]  = '{1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h5F, 8'h5F};
        vecs[8]  = '{1'b1, 4'd9, 1'b1, 4'd2, 8'h3C, 8'hFF, 1'b1, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, 4'd2, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'h3C, 8'h3C};
        vecs[10] = '{1'b1, 4'd2, 1'b1, 4'd2, 8'hFF, 8'h81, 1'b1, 8'hBD, 8'h3C};
        vecs[11] = '{1'b1, 4'd2, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'hBD, 8'hBD};
        vecs[12] = '{1'b0, 4'd0, 1'b1, 4'd4, 8'hFF, 8'h00, 1'b0, 8'hBD, 8'hBD};
        vecs[13] = '{1'b1, 4'd4, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};

        rst = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; mbist_start = 1'b0;
        rd_addr = '0; wr_addr = '0; data_in = '0; data_mask_in = '0;
        repeat (2) tick;
        check("rst_data_out", data_out, 8'h00);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fail", fail, 1'b0);
        check("rst_fail_addr", fail_addr, 4'h0);

        // Functional requests during INIT must be ignored.
        rd_en = 1'b1; rd_addr = 4'd0;
        wr_en = 1'b1; wr_addr = 4'd0; data_in = 8'hFF; data_mask_in = 8'hFF;
        rst = 1'b0;
        wait_ready(n, leaks);
        rd_en = 1'b0; wr_en = 1'b0;
        check("init_ready_latency", n, 16);
        check("init_rd_valid_gated", leaks, 0);

        for (int i = 0; i < 14; i++) begin
            rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
            data_in = vecs[i].data; data_mask_in = vecs[i].mask;
            tick;
            $display("vec %0d: rd=%0b@%0d wr=%0b@%0d d=%02h m=%02h -> valid=%0b out=%02h out_nb=%02h",
                     i, vecs[i].rd_en, vecs[i].rd_addr, vecs[i].wr_en, vecs[i].wr_addr,
                     vecs[i].data, vecs[i].mask, rd_valid, data_out, data_out_nb);
            check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data_byp", i), data_out, vecs[i].exp_byp);
            check($sformatf("vec%0d_data_nobyp", i), data_out_nb, vecs[i].exp_nb);
        end
        rd_en = 1'b0; wr_en = 1'b0;
        tick;
        check("rd_valid_pulse_end", rd_valid, 1'b0);

        run_march(-1, n, ff, ffa, vl, fb);
        check("march_busy_cycles", n, 161);
        check("march_done", done, 1'b1);
        check("march_fail", fail, 1'b0);
        check("march_rd_valid_quiet", vl, 0);
        check("march_ready_after", ready, 1'b1);
        tick;
        check("march_done_held", done, 1'b1);
        for (int a = 0; a < 16; a++) begin
            read_word(a[3:0], d, v);
            $display("post-march read addr %0d -> valid=%0b data=%02h", a, v, d);
            check($sformatf("post_march_zero_%0d", a), {v, d}, 9'h100);
        end

        inject = 1'b1;
        run_march(-1, n, ff, ffa, vl, fb);
        check("fault_busy_cycles", n, 161);
        check("fault_first_fail_cycle", ff, 28);
        check("fault_first_fail_addr", ffa, 4'd5);
        check("fault_fail_sticky", fail, 1'b1);
        check("fault_fail_addr_kept", fail_addr, 4'd5);
        check("fault_done", done, 1'b1);
        check("fault_other_inst_clean", fail_nb, 1'b0);

        run_march(40, n, ff, ffa, vl, fb);
        check("abort_fail_before_rst", fb, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_fail", fail, 1'b0);
        check("abort_fail_addr", fail_addr, 4'd0);
        check("abort_done", done, 1'b0);
        check("abort_ready", ready, 1'b0);
        inject = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        wait_ready(n, leaks);
        check("abort_ready_latency", n, 16);
        read_word(4'd5, d, v);
        $display("post-abort read addr 5 -> valid=%0b data=%02h", v, d);
        check("abort_addr5_zero", {v, d}, 9'h100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
